// File: rtl/serial_pattern_tx_if.sv
// ----------------------------------------------------------------------------
// serial_pattern_tx_if
// Purpose : bundles the request/data inputs and the serial/status outputs of
//           serial_pattern_tx so they travel as one port.
// Signals :
//   start   master->slave  transfer request (honoured only while ready=1)
//   pattern master->slave  frame bits, pattern[len-1] sent first
//   len     master->slave  frame length (0 or >WIDTH means WIDTH)
//   reps    master->slave  extra repetitions (frames = reps+1)
//   abort   master->slave  cancel the running transfer
//   x_out   slave->master  serial data bit
//   valid   slave->master  x_out carries a pattern bit
//   ready   slave->master  idle, start can be accepted
//   busy    slave->master  inverse of ready
//   done    slave->master  one-cycle pulse after the last bit of the last frame
// ----------------------------------------------------------------------------
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic             abort;
    logic             x_out;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, reps, abort,
        input  x_out, valid, ready, busy, done
    );

    modport slave (
        input  start, pattern, len, reps, abort,
        output x_out, valid, ready, busy, done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// ----------------------------------------------------------------------------
// serial_pattern_tx
// Purpose : serial bit-pattern transmitter. Captures a 1..WIDTH bit pattern,
//           shifts it out MSB-first one bit per clock, repeats the frame
//           reps+1 times with GAP idle cycles between frames, then pulses done.
// Ports   :
//   clk  in  clock, all state changes on posedge
//   rst  in  asynchronous active-low reset
//   bus  slave modport of serial_pattern_tx_if (start/pattern/len/reps/abort
//        in; x_out/valid/ready/busy/done out, all registered)
// ----------------------------------------------------------------------------
module serial_pattern_tx #(
    parameter int   WIDTH    = 8,
    parameter int   LEN_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP      = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_pattern_tx_if.slave   bus
);

    // Gap counter runs GAP-1 down to 0.
    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_frame;      // pattern left-aligned, reloaded per frame
    logic [WIDTH-1:0]   r_shift;      // working copy, MSB is the next bit
    logic [LEN_W-1:0]   r_last_idx;   // len-1
    logic [LEN_W-1:0]   r_cnt;        // bits remaining in frame after this one
    logic [CNT_W-1:0]   r_reps_left;
    logic [GAP_W-1:0]   r_gap;
    logic               r_fin;        // last frame completed normally -> done next
    logic               r_x;
    logic               r_valid;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;

    logic [LEN_W-1:0]   w_len;
    logic [WIDTH-1:0]   w_frame;
    logic               w_accept;

    assign w_len = ((bus.len == '0) || (bus.len > LEN_MAX)) ? LEN_MAX : bus.len;

    // Left-align so pattern[len-1] lands in the MSB and shifting left walks
    // down to pattern[0].
    assign w_frame = bus.pattern << (LEN_MAX - w_len);

    // ready is registered one cycle behind the state, so both must agree
    // before a start is taken; abort wins over a simultaneous start.
    assign w_accept = bus.start && !bus.abort && r_ready && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_shift     <= '0;
            r_last_idx  <= '0;
            r_cnt       <= '0;
            r_reps_left <= '0;
            r_gap       <= '0;
            r_fin       <= 1'b0;
            r_x         <= IDLE_VAL;
            r_valid     <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_x     <= IDLE_VAL;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= r_fin;
                    r_fin   <= 1'b0;
                    if (w_accept) begin
                        r_frame     <= w_frame;
                        r_shift     <= w_frame;
                        r_last_idx  <= w_len - 1'b1;
                        r_cnt       <= w_len - 1'b1;
                        r_reps_left <= bus.reps;
                        r_state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_x     <= IDLE_VAL;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_fin   <= 1'b0;
                    end else begin
                        r_x     <= r_shift[WIDTH-1];
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (r_cnt == '0) begin
                            if (r_reps_left != '0) begin
                                r_reps_left <= r_reps_left - 1'b1;
                                r_shift     <= r_frame;
                                r_cnt       <= r_last_idx;
                                if (GAP > 0) begin
                                    r_gap   <= GAP_LAST;
                                    r_state <= S_GAP;
                                end
                            end else begin
                                r_fin   <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_shift <= r_shift << 1;
                            r_cnt   <= r_cnt - 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    r_x     <= IDLE_VAL;
                    r_valid <= 1'b0;
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_fin   <= 1'b0;
                    end else begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (r_gap == '0) begin
                            r_state <= S_SHIFT;
                        end else begin
                            r_gap <= r_gap - 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.x_out = r_x;
    assign bus.valid = r_valid;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// ----------------------------------------------------------------------------
// tb_serial_pattern_tx
// Directed bench for serial_pattern_tx (WIDTH=8, GAP=2). Each cycle the
// outputs are packed as {x_out, valid, ready, busy, done} and compared with a
// hand-written table. Cycle 0 is the cycle after the edge that takes start.
// ----------------------------------------------------------------------------
module tb_serial_pattern_tx;

    localparam logic [4:0] O_IDL = 5'b00100;  // idle, ready
    localparam logic [4:0] O_HI  = 5'b11010;  // bit 1, valid, busy
    localparam logic [4:0] O_LO  = 5'b01010;  // bit 0, valid, busy
    localparam logic [4:0] O_GAP = 5'b00010;  // gap, busy
    localparam logic [4:0] O_DON = 5'b00101;  // done pulse, ready

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    serial_pattern_tx_if #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) bus ();

    serial_pattern_tx #(
        .WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP(2), .IDLE_VAL(1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [4:0] obs;
    assign obs = {bus.x_out, bus.valid, bus.ready, bus.busy, bus.done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        bus.start   = 1'b1;
        bus.pattern = p;
        bus.len     = l;
        bus.reps    = r;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_vec++;
        if (obs !== O_IDL) begin
            n_err++; $display("FAIL reset_held: got %b expected %b", obs, O_IDL);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (obs !== O_IDL) begin
            n_err++; $display("FAIL reset_release: got %b expected %b", obs, O_IDL);
        end
    endtask

    task automatic test_single();
        logic [4:0] exp [0:5];
        exp = '{O_IDL, O_HI, O_HI, O_LO, O_DON, O_IDL};
        do_start(8'h06, 4'd3, 4'd0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++; $display("FAIL single c%0d: got %b expected %b", k, obs, exp[k]);
            end
        end
    endtask

    task automatic test_gap_reps();
        logic [4:0] exp [0:10];
        exp = '{O_IDL, O_HI, O_LO, O_HI, O_GAP, O_GAP, O_HI, O_LO, O_HI, O_DON, O_IDL};
        do_start(8'h05, 4'd3, 4'd1);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++; $display("FAIL gap_reps c%0d: got %b expected %b", k, obs, exp[k]);
            end
        end
    endtask

    task automatic test_clamp();
        logic [4:0] exp0 [0:10];
        logic [4:0] exp9 [0:10];
        exp0 = '{O_IDL, O_HI, O_LO, O_HI, O_LO, O_LO, O_HI, O_LO, O_HI, O_DON, O_IDL};
        exp9 = '{O_IDL, O_LO, O_LO, O_HI, O_HI, O_HI, O_HI, O_LO, O_LO, O_DON, O_IDL};
        do_start(8'hA5, 4'd0, 4'd0);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp0[k]) begin
                n_err++; $display("FAIL clamp_len0 c%0d: got %b expected %b", k, obs, exp0[k]);
            end
        end
        do_start(8'h3C, 4'd9, 4'd0);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp9[k]) begin
                n_err++; $display("FAIL clamp_len9 c%0d: got %b expected %b", k, obs, exp9[k]);
            end
        end
    endtask

    task automatic test_len1();
        logic [4:0] exp [0:9];
        exp = '{O_IDL, O_HI, O_GAP, O_GAP, O_HI, O_GAP, O_GAP, O_HI, O_DON, O_IDL};
        do_start(8'h01, 4'd1, 4'd2);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++; $display("FAIL len1 c%0d: got %b expected %b", k, obs, exp[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0] exp  [0:5];
        logic [4:0] exp2 [0:5];
        exp  = '{O_IDL, O_HI, O_LO, O_IDL, O_IDL, O_IDL};
        exp2 = '{O_IDL, O_HI, O_HI, O_LO, O_DON, O_IDL};
        do_start(8'h16, 4'd5, 4'd0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++; $display("FAIL abort c%0d: got %b expected %b", k, obs, exp[k]);
            end
            bus.abort = (k == 2);
        end
        do_start(8'h06, 4'd3, 4'd0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp2[k]) begin
                n_err++; $display("FAIL after_abort c%0d: got %b expected %b", k, obs, exp2[k]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [4:0] exp [0:6];
        exp = '{O_IDL, O_HI, O_HI, O_LO, O_DON, O_IDL, O_IDL};
        do_start(8'h06, 4'd3, 4'd0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++; $display("FAIL busy_ignore c%0d: got %b expected %b", k, obs, exp[k]);
            end
            if (k == 1) begin
                bus.start = 1'b1; bus.pattern = 8'hFF; bus.len = 4'd8; bus.reps = 4'd3;
            end
            if (k == 2) bus.start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp [0:10];
        exp = '{O_IDL, O_HI, O_HI, O_LO, O_DON, O_IDL, O_HI, O_LO, O_HI, O_DON, O_IDL};
        do_start(8'h06, 4'd3, 4'd0);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++; $display("FAIL back_to_back c%0d: got %b expected %b", k, obs, exp[k]);
            end
            if (k == 3) begin
                bus.start = 1'b1; bus.pattern = 8'h05; bus.len = 4'd3; bus.reps = 4'd0;
            end
            if (k == 5) bus.start = 1'b0;
        end
    endtask

    task automatic test_max_reps();
        int nv;
        int nb;
        int nbad;
        bit seen;
        nv = 0; nb = 0; nbad = 0; seen = 1'b0;
        do_start(8'h01, 4'd1, 4'd15);
        for (int k = 0; k < 120 && !seen; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.valid) begin
                    nv++;
                    if (bus.x_out !== 1'b1) nbad++;
                end
                if (bus.busy) nb++;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL max_reps_done: got 0 expected 1 within 120 cycles");
        end
        n_vec++;
        if (nv != 16) begin
            n_err++; $display("FAIL max_reps_frames: got %0d expected 16", nv);
        end
        n_vec++;
        if (nb != 46) begin
            n_err++; $display("FAIL max_reps_busy: got %0d expected 46", nb);
        end
        n_vec++;
        if (nbad != 0) begin
            n_err++; $display("FAIL max_reps_bits: got %0d bad bits expected 0", nbad);
        end
        @(posedge clk); #1;
        n_vec++;
        if (obs !== O_IDL) begin
            n_err++; $display("FAIL max_reps_after: got %b expected %b", obs, O_IDL);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] exp  [0:4];
        logic [4:0] exp2 [0:4];
        exp  = '{O_IDL, O_HI, O_LO, O_HI, O_GAP};
        exp2 = '{O_IDL, O_HI, O_HI, O_DON, O_IDL};
        do_start(8'h05, 4'd3, 4'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++; $display("FAIL pre_reset c%0d: got %b expected %b", k, obs, exp[k]);
            end
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (obs !== O_IDL) begin
            n_err++; $display("FAIL async_reset: got %b expected %b", obs, O_IDL);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (obs !== O_IDL) begin
                n_err++; $display("FAIL post_reset c%0d: got %b expected %b", k, obs, O_IDL);
            end
        end
        do_start(8'h03, 4'd2, 4'd0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_vec++;
            if (obs !== exp2[k]) begin
                n_err++; $display("FAIL recover c%0d: got %b expected %b", k, obs, exp2[k]);
            end
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.reps    = '0;
        bus.abort   = 1'b0;

        test_reset();
        test_single();
        test_gap_reps();
        test_clamp();
        test_len1();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        test_max_reps();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
